// File: rtl/rca_arb_pkg.sv
// Shared constants, helper function and ID type for the round-robin adder arbiter.
package rca_arb_pkg;

    localparam int DATA_W      = 32;
    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Requester index type for the default configuration
    typedef logic [clog2(NUM_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/rca32.sv
// 32-bit ripple-carry adder, purely combinational datapath shared by the arbiter.
module rca32
    import rca_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ci,
    output logic [DATA_W-1:0] s,
    output logic              co
);

    logic carry;

    always_comb begin
        carry = ci;
        s     = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/rca_rr_pick.sv
// Combinational round-robin picker: first set req strictly above ptr, else lowest set req.
module rca_rr_pick
    import rca_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [ID_W-1:0]    win_idx,
    output logic               any
);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] pool;

    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (ID_W'(i) > ptr);
        end
        hi_req = req & hi_mask;
        // Wrap-around: when nothing is set above ptr, restart from index 0
        pool   = (hi_req != '0) ? hi_req : req;

        win_oh  = '0;
        win_idx = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (pool[i-1]) begin
                win_oh       = '0;
                win_oh[i-1]  = 1'b1;
                win_idx      = ID_W'(i - 1);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rca_arbiter.sv
// Round-robin shared registered 32-bit adder; result two edges after operand sampling.
// Optional signed-overflow output ovf_rca is enabled by defining RCA_ARB_OVF_EN.
module rca_arbiter
    import rca_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] a_in,
    input  logic [NUM_REQ*DATA_W-1:0] b_in,
    input  logic [NUM_REQ-1:0]        ci_in,
    input  logic                      accept_en,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         s_rca,
    output logic                      co_rca,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          op_count
`ifdef RCA_ARB_OVF_EN
   ,output logic                      ovf_rca
`endif
);

    logic [ID_W-1:0]    ptr_q,  ptr_d;
    logic [NUM_REQ-1:0] gnt_q,  gnt_d;
    logic [DATA_W-1:0]  a_q,    a_d;
    logic [DATA_W-1:0]  b_q,    b_d;
    logic               ci_q,   ci_d;
    logic               v1_q,   v1_d;
    logic [ID_W-1:0]    id1_q,  id1_d;
    logic [DATA_W-1:0]  s_q,    s_d;
    logic               co_q,   co_d;
    logic               rv_q,   rv_d;
    logic [ID_W-1:0]    rid_q,  rid_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win_idx;
    logic               any_req;
    logic [DATA_W-1:0]  a_sel, b_sel;
    logic               ci_sel;
    logic [DATA_W-1:0]  sum;
    logic               sum_co;

    rca_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any_req)
    );

    rca32 u_rca (
        .a  (a_q),
        .b  (b_q),
        .ci (ci_q),
        .s  (sum),
        .co (sum_co)
    );

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        ci_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                a_sel  = a_in[i*DATA_W +: DATA_W];
                b_sel  = b_in[i*DATA_W +: DATA_W];
                ci_sel = ci_in[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        gnt_d = '0;
        a_d   = a_q;
        b_d   = b_q;
        ci_d  = ci_q;
        v1_d  = 1'b0;
        id1_d = id1_q;
        if (accept_en && any_req) begin
            a_d   = a_sel;
            b_d   = b_sel;
            ci_d  = ci_sel;
            v1_d  = 1'b1;
            id1_d = win_idx;
            gnt_d = win_oh;
            ptr_d = win_idx;
        end

        rv_d  = v1_q;
        rid_d = id1_q;
        s_d   = v1_q ? sum    : s_q;
        co_d  = v1_q ? sum_co : co_q;
        cnt_d = (v1_q && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
            gnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ci_q  <= 1'b0;
            v1_q  <= 1'b0;
            id1_q <= '0;
            s_q   <= '0;
            co_q  <= 1'b0;
            rv_q  <= 1'b0;
            rid_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ci_q  <= ci_d;
            v1_q  <= v1_d;
            id1_q <= id1_d;
            s_q   <= s_d;
            co_q  <= co_d;
            rv_q  <= rv_d;
            rid_q <= rid_d;
            cnt_q <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign s_rca     = s_q;
    assign co_rca    = co_q;
    assign rsp_valid = rv_q;
    assign rsp_id    = rid_q;
    assign op_count  = cnt_q;

`ifdef RCA_ARB_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (v1_q) begin
            ovf_d = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_rca = ovf_q;
`endif

endmodule

// File: tb/tb_rca_arbiter.sv
// Scoreboard bench for rca_arbiter (NUM_REQ=4, CNT_W=4 so saturation is reachable).
module tb_rca_arbiter;
    import rca_arb_pkg::*;

    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*32-1:0] a_in = '0;
    logic [N*32-1:0] b_in = '0;
    logic [N-1:0]    ci_in = '0;
    logic            accept_en = 1'b1;
    logic [N-1:0]    gnt;
    logic [31:0]     s_rca;
    logic            co_rca;
    logic            rsp_valid;
    req_id_t         rsp_id;
    logic [3:0]      op_count;
`ifdef RCA_ARB_OVF_EN
    logic            ovf_rca;
`endif

    rca_arbiter #(
        .NUM_REQ (N),
        .CNT_W   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ci_in     (ci_in),
        .accept_en (accept_en),
        .gnt       (gnt),
        .s_rca     (s_rca),
        .co_rca    (co_rca),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
`ifdef RCA_ARB_OVF_EN
       ,.ovf_rca   (ovf_rca)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          mptr     = N - 1;
    logic        inflight = 1'b0;
    int          mcnt     = 0;
    logic [31:0] last_s   = '0;
    logic        last_co  = 1'b0;
    logic        last_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic ci);
        a_in[i*32 +: 32] = a;
        b_in[i*32 +: 32] = b;
        ci_in[i]         = ci;
    endtask

    // One clock: model the edge, push/pop the scoreboard, check, return at negedge.
    task automatic cycle();
        exp_t        e;
        int          w;
        int          c;
        logic [32:0] full;
        logic        due;
        logic [N-1:0] exp_gnt;
        @(posedge clock);
        due = inflight;
        w   = -1;
        if (accept_en && req != '0) begin
            for (int off = 1; off <= N; off++) begin
                c = (mptr + off) % N;
                if (w < 0 && req[c]) w = c;
            end
        end
        if (w >= 0) begin
            full  = {1'b0, a_in[w*32 +: 32]} + {1'b0, b_in[w*32 +: 32]} + {32'b0, ci_in[w]};
            e.id  = w;
            e.s   = full[31:0];
            e.co  = full[32];
            e.ovf = (a_in[w*32+31] == b_in[w*32+31]) && (full[31] != a_in[w*32+31]);
            exp_q.push_back(e);
            mptr     = w;
            exp_gnt  = '0;
            exp_gnt[w] = 1'b1;
            inflight = 1'b1;
        end else begin
            exp_gnt  = '0;
            inflight = 1'b0;
        end
        if (due && mcnt != 15) mcnt++;
        #1;
        check_eq("gnt", gnt, exp_gnt);
        check_eq("rsp_valid", rsp_valid, due);
        if (due && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rsp_id", rsp_id, e.id);
            check_eq("s_rca", s_rca, e.s);
            check_eq("co_rca", co_rca, e.co);
            last_s  = e.s;
            last_co = e.co;
            last_ovf = e.ovf;
        end else begin
            check_eq("s_hold", s_rca, last_s);
            check_eq("co_hold", co_rca, last_co);
        end
`ifdef RCA_ARB_OVF_EN
        check_eq("ovf_rca", ovf_rca, last_ovf);
`endif
        check_eq("op_count", op_count, mcnt);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_s", s_rca, 0);
        check_eq("rst_co", co_rca, 0);
        check_eq("rst_op_count", op_count, 0);
        exp_q.delete();
        mptr = N - 1;
        inflight = 1'b0;
        mcnt = 0;
        last_s = '0;
        last_co = 1'b0;
        last_ovf = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        // Single requester
        set_op(2, 32'h5, 32'h3, 1'b1);
        req = 4'b0100;
        cycle();
        check_eq("single_gnt", gnt, 4'b0100);
        req = '0;
        cycle();
        check_eq("single_valid", rsp_valid, 1);
        check_eq("single_id", rsp_id, 2);
        check_eq("single_s", s_rca, 32'h9);
        check_eq("single_co", co_rca, 0);
        check_eq("single_cnt", op_count, 1);
        cycle();

        // Round-robin with all requesters held high
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'h100 * (i + 1), 32'h11 + i, i[0]);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_eq("rr_gnt", gnt, 4'b0001 << (i % 4));
        end
        req = '0;
        cycle();
        check_eq("rr_last_id", rsp_id, 3);
        check_eq("rr_cnt", op_count, 8);
        cycle();

        // Carry wrap
        set_op(1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req = 4'b0010;
        cycle();
        req = '0;
        cycle();
        check_eq("wrap_s", s_rca, 32'h0);
        check_eq("wrap_co", co_rca, 1);
        set_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        req = 4'b0001;
        cycle();
        req = '0;
        cycle();
        check_eq("ovf_s", s_rca, 32'hFFFF_FFFE);
        check_eq("ovf_co", co_rca, 0);
`ifdef RCA_ARB_OVF_EN
        check_eq("ovf_flag", ovf_rca, 1);
`endif
        cycle();

        // accept_en low drains the in-flight op and freezes the pointer
        set_op(1, 32'h1234, 32'h1, 1'b0);
        set_op(0, 32'hA, 32'hB, 1'b0);
        set_op(3, 32'hC0DE, 32'h2, 1'b1);
        req = 4'b0010;
        cycle();
        check_eq("acc_gnt1", gnt, 4'b0010);
        accept_en = 1'b0;
        req = 4'b1001;
        cycle();
        check_eq("acc_nognt", gnt, 0);
        check_eq("acc_drain_id", rsp_id, 1);
        check_eq("acc_drain_v", rsp_valid, 1);
        cycle();
        check_eq("acc_nognt2", gnt, 0);
        accept_en = 1'b1;
        cycle();
        check_eq("acc_next", gnt, 4'b1000);
        req = '0;
        cycle();
        cycle();

        // Reset mid-operation
        set_op(2, 32'h77, 32'h1, 1'b0);
        req = 4'b0100;
        cycle();
        check_eq("mid_gnt", gnt, 4'b0100);
        req = 4'b1010;
        do_reset();
        cycle();
        check_eq("mid_nov", rsp_valid, 0);
        check_eq("mid_first", gnt, 4'b0010);
        req = '0;
        cycle();
        cycle();

        // Counter saturation: back-to-back grants to a lone requester
        do_reset();
        set_op(0, 32'h1, 32'h1, 1'b0);
        req = 4'b0001;
        for (int i = 0; i < 20; i++) cycle();
        req = '0;
        cycle();
        cycle();
        check_eq("sat_cnt", op_count, 15);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rca_arbiter.md
Name: rca_arbiter

Overview:
Shares one registered 32-bit ripple-carry adder (rca32) between NUM_REQ requesters using round-robin arbitration.
- Each requester presents a, b and ci with a level req.
- The block grants one requester per cycle, registers its operands, and returns the registered sum, carry and requester ID two clock edges after sampling.
- Sits between independent compute clients and the single shared adder datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 16, width of completed-operation counter
ID_W, $clog2(NUM_REQ), derived localparam: requester ID width (not overridable)

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state
req  in  NUM_REQ  per-requester operand valid (level)
a_in  in  NUM_REQ*32  packed operand A; requester i in bits [32i+31:32i]
b_in  in  NUM_REQ*32  packed operand B, same packing
ci_in  in  NUM_REQ  per-requester carry-in
accept_en  in  1  1 = arbiter may grant; 0 = no new grants, in-flight op drains
gnt  out  NUM_REQ  registered one-hot; high one cycle = operands sampled at previous edge consumed
s_rca  out  32  registered sum
co_rca  out  1  registered carry-out
rsp_valid  out  1  s_rca/co_rca/rsp_id valid this cycle (one-cycle pulse per op)
rsp_id  out  ID_W  index of requester owning the result
op_count  out  CNT_W  saturating count of completed ops

Behaviour:
- Reset values: gnt=0, s_rca=0, co_rca=0, rsp_valid=0, rsp_id=0, op_count=0, operand regs=0, stage-1 valid=0, rr pointer=NUM_REQ-1 (req[0] highest priority first).
- Edge k (grant): if accept_en=1 and req!=0, winner = first set req searching from ptr+1 upward, wrapping at NUM_REQ.
  - Register winner's a/b/ci into operand regs.
  - Set stage-1 valid=1 and stage-1 id=winner.
  - gnt=one-hot(winner); ptr=winner.
  - Otherwise: gnt=0, stage-1 valid=0, operand regs and ptr hold.
- Edge k+1 (result): rca32 output on operand regs registered into s_rca/co_rca; rsp_valid=stage-1 valid; rsp_id=stage-1 id.
  - When stage-1 valid=0, s_rca/co_rca hold previous values.
- Latency: operands sampled at edge k appear on outputs after edge k+1. Throughput: one op per cycle; back-to-back grants allowed, including to the same requester when it is the only one requesting.
- Requester protocol:
  - Hold req and operands stable until gnt seen.
  - In the gnt cycle, drop req or present the next operation before the following edge.
  - A req held high through gnt is treated as a new operation.
- accept_en=0: no grant, ptr frozen; an op granted on the previous edge still completes with rsp_valid. Nothing is lost or duplicated.
- Arithmetic: {co_rca,s_rca} = a+b+ci modulo 2^33; no saturation.
- op_count: +1 on each edge where stage-1 valid=1; saturates at 2^CNT_W-1, never wraps.
- No result backpressure: consumer must accept rsp_valid in its cycle.
- Reset mid-operation: in-flight op discarded, no rsp_valid after reset deasserts, ptr returns to NUM_REQ-1.
- Requesters whose req is low are never granted. Operand bits of non-granted requesters are ignored.

Optional Feature:
Macro RCA_ARB_OVF_EN.
- Defined: adds output port ovf_rca (1 bit), registered with s_rca. It equals signed overflow: (a[31]==b[31]) && (s[31]!=a[31]). Reset 0; holds when stage-1 valid=0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package rca_arb_pkg: DATA_W=32, default NUM_REQ, CNT_W; function clog2; typedef req_id_t.
- Sub-module rca_rr_pick: combinational round-robin picker (req, ptr -> winner one-hot, winner index, any).
- Existing rca32 instantiated unchanged as the datapath.
- Top holds registers, counter and handshake.

Test Plan:
- Single requester: req[2]=1, a=0x00000005, b=0x00000003, ci=1, accept_en=1.
  - gnt=0b0100 for one cycle.
  - Next cycle: rsp_valid=1, rsp_id=2, s_rca=0x00000009, co_rca=0, op_count=1.
- Round-robin: all four req held high for 8 cycles after reset -> gnt sequence 0,1,2,3,0,1,2,3; rsp_id follows one cycle later; op_count=8.
- Carry wrap: a=0xFFFFFFFF, b=0x00000000, ci=1 -> s_rca=0x00000000, co_rca=1.
  - With RCA_ARB_OVF_EN, a=b=0x7FFFFFFF, ci=0 -> s=0xFFFFFFFE, ovf_rca=1.
- accept_en low: grant req[1], drop accept_en the following cycle with req[0,3] high.
  - Pending op returns rsp_id=1.
  - No gnt while low.
  - On re-enable, the next grant goes to req[3] (ptr=1, search 2,3).
- Reset mid-op: assert reset the cycle after a gnt.
  - All outputs go to 0 immediately (async).
  - No rsp_valid after release.
  - First subsequent grant goes to lowest-index active req.
- Counter saturation: CNT_W=4, 20 back-to-back ops -> op_count stops at 15.
